audio_dac_scheduler: RTL and testbench
======================================

// Module: audio_dac_scheduler
// PURPOSE
//  Sample scheduler/sequencer in front of the stereo hybrid PWM/SD DAC. On each
//  sample tick it accepts one stereo sample from each of two requesters (A: Paula
//  mix, B: aux stream), mixes them with saturation, applies a fade volume, and
//  drives the DAC's offset-binary inputs. Owns power-on fade-in and core-change
//  fade-out, then asserts the DAC's terminate input for its anti-pop ramp.
// PARAMETERS
//  FADE_TICKS  48  sample ticks per volume step (64 steps; 48 -> ~64 ms at 48 kHz)
// PORTS
//  clk           in   1   system clock; everything is synchronous to it
//  reset         in   1   asynchronous, active-high reset
//  tick          in   1   sample strobe, one clk wide, >=8 clks apart
//  a_valid       in   1   requester A has a sample
//  a_ready       out  1   A sample taken this cycle
//  a_l, a_r      in   16  A sample, signed two's complement
//  b_enable      in   1   aux stream enabled
//  b_valid       in   1   requester B has a sample
//  b_ready       out  1   B sample taken this cycle
//  b_l, b_r      in   16  B sample, signed two's complement
//  shutdown_req  in   1   core change pending (level)
//  shutdown_ack  out  1   fade-out done, terminate asserted
//  terminate     out  1   to DAC terminate input
//  d_l, d_r      out  16  to DAC, offset binary (0x8000 = silence)
//  underrun      out  1   1-clk pulse: tick with a requester not valid
//  clipped       out  1   1-clk pulse: mix saturated on either channel
// BEHAVIOUR
//  Reset: d_l=d_r=16'h8000, terminate=0, shutdown_ack=0, a_ready=b_ready=0,
//   underrun=clipped=0, volume=0, fade counter=0, held samples=0, state=FADE_IN.
//  FSM: FADE_IN -> RUN -> FADE_OUT -> TERM. Volume vol is 0..64.
//   FADE_IN: every FADE_TICKS ticks vol+=1; at vol==64 go to RUN.
//   RUN: vol held at 64.
//   shutdown_req=1 in FADE_IN or RUN: go to FADE_OUT the next clk. vol keeps its
//    value and the fade counter clears.
//   FADE_OUT: every FADE_TICKS ticks vol-=1; at vol==0 go to TERM.
//   TERM: terminate=1 and shutdown_ack=1 from the clk TERM is entered. Sticky
//    until reset. Ticks are ignored, readies stay 0, d_l/d_r hold 16'h8000.
//   Dropping shutdown_req in FADE_OUT has no effect; the fade-out always completes.
//  Handshake, on the tick clk (not in TERM):
//   a_ready=1. Transfer when a_valid, latched into held_a.
//   b_ready=b_enable. Transfer when b_valid&b_enable.
//   No transfer: previous held sample repeats and underrun pulses. For B this
//    applies only when b_enable=1.
//   b_enable=0: B contributes 0, and held_b clears on that tick.
//   Readies are 0 on every non-tick clk.
//  Pipeline, with the tick at T:
//   T+1: held samples valid.
//   T+2: s = held_a + held_b as 17-bit signed, saturated to [-32768, 32767].
//    clipped pulses if either channel saturated.
//   T+3: one shared multiplier computes (s_l*vol)>>>6 (arithmetic shift, floor).
//   T+4: the same for s_r.
//   T+5: d_l and d_r update together, d = product ^ 16'h8000.
//   vol is sampled once per sample at T+2, so L and R use the same vol.
//  vol==0 gives exactly 16'h8000. vol==64 passes s through unchanged.
//  Same-cycle tick and shutdown_req: the sample is accepted and the FSM moves.
//   That sample uses the pre-transition vol.
//  The fade counter advances only on ticks. It wraps to 0 at each vol step.
//  Reset mid-fade or in TERM: immediate return to the reset state, and the
//   terminate deassert is asynchronous.
// TESTING
//  1 reset, FADE_TICKS=2, A=+0x4000 constant each tick -> vol reaches 64 after
//    128 ticks; then d_l=0xC000 with 5-clk latency from tick.
//  2 RUN, A=0x7000, B=0x7000, b_enable=1 -> d_l=0xFFFF, clipped pulses.
//    A=-0x7000, B=-0x7000 -> d_l=0x0000.
//  3 RUN, vol forced 32 via fade, A_l=-1 -> product -1>>>6 = -1 -> d_l=0x7FFF
//    (floor rounding check).
//  4 RUN, a_valid=0 on a tick -> underrun pulse, d_l repeats previous value,
//    a_ready still high for that clk.
//  5 RUN, shutdown_req pulse 1 clk -> 64*FADE_TICKS ticks later terminate=1 and
//    shutdown_ack=1, d=0x8000. Further ticks give ready=0.
//  6 assert reset during FADE_OUT (vol=20) -> same clk: terminate=0,
//    d=0x8000, state FADE_IN with vol=0.

Source files
------------

// File: rtl/audio_dac_scheduler_if.sv
// Bundles the sample handshakes, the shutdown handshake and the DAC-facing
// outputs of the audio DAC scheduler. The master side is whatever produces
// samples and requests shutdown. The slave side is the scheduler itself.
interface audio_dac_scheduler_if;
    logic               tick;
    logic               a_valid;
    logic               a_ready;
    logic signed [15:0] a_l;
    logic signed [15:0] a_r;
    logic               b_enable;
    logic               b_valid;
    logic               b_ready;
    logic signed [15:0] b_l;
    logic signed [15:0] b_r;
    logic               shutdown_req;
    logic               shutdown_ack;
    logic               terminate;
    logic [15:0]        d_l;
    logic [15:0]        d_r;
    logic               underrun;
    logic               clipped;

    modport master (
        output tick, a_valid, a_l, a_r, b_enable, b_valid, b_l, b_r, shutdown_req,
        input  a_ready, b_ready, shutdown_ack, terminate, d_l, d_r, underrun, clipped
    );

    modport slave (
        input  tick, a_valid, a_l, a_r, b_enable, b_valid, b_l, b_r, shutdown_req,
        output a_ready, b_ready, shutdown_ack, terminate, d_l, d_r, underrun, clipped
    );
endinterface

// File: rtl/audio_dac_scheduler.sv
// Sample scheduler in front of the stereo PWM/SD DAC.
// On each tick it takes one stereo sample from each of two requesters and mixes
// them with saturation. It then scales the mix by the fade volume and presents
// the result to the DAC in offset binary.
// It fades in after reset and fades out on a core change. After the fade-out it
// holds the DAC in terminate until the next reset.
module audio_dac_scheduler #(
    parameter int FADE_TICKS = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    audio_dac_scheduler_if.slave  bus
);

    localparam int              CNT_W    = (FADE_TICKS > 1) ? $clog2(FADE_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_TICKS - 1);

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        RUN      = 2'd1,
        FADE_OUT = 2'd2,
        TERM     = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [6:0]       vol_reg, vol_next;
    logic [CNT_W-1:0] fade_cnt_reg, fade_cnt_next;

    // Pipeline stage markers: p1 = held samples valid, p2 = saturated mix valid,
    // p3 = left product valid, p4 = right product valid (d loads next).
    logic             p1_reg, p2_reg, p3_reg, p4_reg;
    logic [6:0]       vol_s_reg;
    logic             underrun_reg;
    logic             clipped_reg;

    logic             accept;
    logic signed [15:0] a_in [2];
    logic signed [15:0] b_in [2];
    logic [15:0]      s_ch [2];
    logic [15:0]      d_ch [2];
    logic             sat_ch [2];

    logic [15:0]      mul_in;
    logic signed [23:0] mul_a;
    logic signed [23:0] mul_b;
    logic signed [23:0] mul_full;
    logic [15:0]      prod_shared;
    logic             unused_mul_bits;

    // A tick is only honoured outside TERM. The readies are combinational, so
    // they are high on exactly the tick clk and low on every other clk.
    assign accept           = bus.tick && (state_reg != TERM);
    assign bus.a_ready      = accept;
    assign bus.b_ready      = accept && bus.b_enable;
    assign bus.terminate    = (state_reg == TERM);
    assign bus.shutdown_ack = (state_reg == TERM);
    assign bus.underrun     = underrun_reg;
    assign bus.clipped      = clipped_reg;
    assign bus.d_l          = d_ch[0];
    assign bus.d_r          = d_ch[1];

    assign a_in[0] = bus.a_l;
    assign a_in[1] = bus.a_r;
    assign b_in[0] = bus.b_l;
    assign b_in[1] = bus.b_r;

    // State, volume and fade counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= FADE_IN;
            vol_reg      <= 7'd0;
            fade_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            vol_reg      <= vol_next;
            fade_cnt_reg <= fade_cnt_next;
        end
    end

    // Fade sequencing. The counter only moves on ticks and wraps at each volume step.
    // A shutdown request freezes the volume where it is and restarts the counter.
    always_comb begin
        state_next    = state_reg;
        vol_next      = vol_reg;
        fade_cnt_next = fade_cnt_reg;
        unique case (state_reg)
            FADE_IN: begin
                if (bus.shutdown_req) begin
                    state_next    = FADE_OUT;
                    fade_cnt_next = '0;
                end else if (bus.tick) begin
                    if (fade_cnt_reg == CNT_LAST) begin
                        fade_cnt_next = '0;
                        vol_next      = vol_reg + 7'd1;
                        if (vol_reg == 7'd63) begin
                            state_next = RUN;
                        end
                    end else begin
                        fade_cnt_next = fade_cnt_reg + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (bus.shutdown_req) begin
                    state_next    = FADE_OUT;
                    fade_cnt_next = '0;
                end
            end
            FADE_OUT: begin
                // A shutdown during the very first step of the fade-in arrives here
                // already silent, so there is nothing left to fade.
                if (vol_reg == 7'd0) begin
                    state_next = TERM;
                end else if (bus.tick) begin
                    if (fade_cnt_reg == CNT_LAST) begin
                        fade_cnt_next = '0;
                        vol_next      = vol_reg - 7'd1;
                        if (vol_reg == 7'd1) begin
                            state_next = TERM;
                        end
                    end else begin
                        fade_cnt_next = fade_cnt_reg + CNT_W'(1);
                    end
                end
            end
            TERM: begin
                state_next = TERM;
            end
            default: begin
                state_next = FADE_IN;
            end
        endcase
    end

    // Stage markers, the per-sample volume snapshot and the status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_reg       <= 1'b0;
            p2_reg       <= 1'b0;
            p3_reg       <= 1'b0;
            p4_reg       <= 1'b0;
            vol_s_reg    <= 7'd0;
            underrun_reg <= 1'b0;
            clipped_reg  <= 1'b0;
        end else begin
            p1_reg       <= accept;
            p2_reg       <= p1_reg;
            p3_reg       <= p2_reg;
            p4_reg       <= p3_reg;
            underrun_reg <= accept && (!bus.a_valid || (bus.b_enable && !bus.b_valid));
            clipped_reg  <= p1_reg && (sat_ch[0] || sat_ch[1]);
            if (p1_reg) begin
                vol_s_reg <= vol_reg;
            end
        end
    end

    // One multiplier serves both channels: left while p2 is high, right while p3 is high.
    // The product is shifted right by 6 with floor rounding, which is the same as
    // taking bits [21:6] of the signed product.
    assign mul_in          = p2_reg ? s_ch[0] : s_ch[1];
    assign mul_a           = $signed({{8{mul_in[15]}}, mul_in});
    assign mul_b           = $signed({17'd0, vol_s_reg});
    assign mul_full        = mul_a * mul_b;
    assign prod_shared     = mul_full[21:6];
    assign unused_mul_bits = ^{mul_full[23:22], mul_full[5:0]};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_ch
            logic signed [15:0] held_a_reg;
            logic signed [15:0] held_b_reg;
            logic [16:0]        sum;
            logic               sat_hi;
            logic               sat_lo;
            logic [15:0]        sat_val;
            logic [15:0]        s_reg;
            logic [15:0]        prod_reg;
            logic [15:0]        d_reg;
            logic               load_prod;

            // Capture this channel's input samples on the tick. On an underrun the
            // old sample repeats. When B is disabled, its held sample is cleared.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    held_a_reg <= '0;
                    held_b_reg <= '0;
                end else if (accept) begin
                    if (bus.a_valid) begin
                        held_a_reg <= a_in[gi];
                    end
                    if (!bus.b_enable) begin
                        held_b_reg <= '0;
                    end else if (bus.b_valid) begin
                        held_b_reg <= b_in[gi];
                    end
                end
            end

            // 17-bit mix. The two top bits disagree exactly when the sum overflowed 16 bits.
            assign sum       = {held_a_reg[15], held_a_reg} + {held_b_reg[15], held_b_reg};
            assign sat_hi    = (sum[16:15] == 2'b01);
            assign sat_lo    = (sum[16:15] == 2'b10);
            assign sat_val   = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : sum[15:0]);
            assign sat_ch[gi] = sat_hi || sat_lo;
            assign s_ch[gi]  = s_reg;
            assign load_prod = (gi == 0) ? p2_reg : p3_reg;
            assign d_ch[gi]  = d_reg;

            // Saturated mix, scaled product and DAC output for this channel.
            // Both d registers load on the same clk. In TERM the output is forced
            // to silence so that a sample still in the pipeline cannot leak out.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s_reg    <= '0;
                    prod_reg <= '0;
                    d_reg    <= 16'h8000;
                end else begin
                    if (p1_reg) begin
                        s_reg <= sat_val;
                    end
                    if (load_prod) begin
                        prod_reg <= prod_shared;
                    end
                    if (state_reg == TERM) begin
                        d_reg <= 16'h8000;
                    end else if (p4_reg) begin
                        d_reg <= prod_reg ^ 16'h8000;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_audio_dac_scheduler.sv
// Directed bench for audio_dac_scheduler with FADE_TICKS=2.
// Ticks come every 8 clks. Each tick transaction records the readies on the
// tick clk, the underrun and clipped pulses, and d just before and just after
// the 5-clk output latency.
module tb_audio_dac_scheduler;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    audio_dac_scheduler_if bus();

    audio_dac_scheduler #(.FADE_TICKS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        r_ra, r_rb, r_und, r_clp;
    logic [15:0] r_dpre, r_dl, r_dr;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // One tick transaction. It starts on a negedge and occupies 8 clks.
    task automatic tick_once(input logic av, input logic [15:0] al, input logic [15:0] ar,
                             input logic be, input logic bv,
                             input logic [15:0] bl, input logic [15:0] br);
        @(negedge clk);
        bus.tick = 1'b1;
        bus.a_valid = av; bus.a_l = al; bus.a_r = ar;
        bus.b_enable = be; bus.b_valid = bv; bus.b_l = bl; bus.b_r = br;
        #1;
        r_ra = bus.a_ready;
        r_rb = bus.b_ready;
        @(negedge clk);
        bus.tick = 1'b0;
        r_und = bus.underrun;
        @(negedge clk);
        r_clp = bus.clipped;
        @(negedge clk);
        @(negedge clk);
        r_dpre = bus.d_l;
        @(negedge clk);
        r_dl = bus.d_l;
        r_dr = bus.d_r;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_ticks(input int n, input logic [15:0] val);
        for (int i = 0; i < n; i++) begin
            tick_once(1'b1, val, val, 1'b0, 1'b0, 16'h0000, 16'h0000);
        end
    endtask

    task automatic pulse_shutdown();
        @(negedge clk);
        bus.shutdown_req = 1'b1;
        @(negedge clk);
        bus.shutdown_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick = 1'b0; bus.a_valid = 1'b0; bus.a_l = '0; bus.a_r = '0;
        bus.b_enable = 1'b0; bus.b_valid = 1'b0; bus.b_l = '0; bus.b_r = '0;
        bus.shutdown_req = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_d_l", bus.d_l, 16'h8000);
        check_eq("rst_d_r", bus.d_r, 16'h8000);
        check_eq("rst_terminate", {15'd0, bus.terminate}, 16'd0);
        check_eq("rst_ack", {15'd0, bus.shutdown_ack}, 16'd0);
        check_eq("rst_a_ready", {15'd0, bus.a_ready}, 16'd0);
        check_eq("rst_underrun", {15'd0, bus.underrun}, 16'd0);
        check_eq("rst_clipped", {15'd0, bus.clipped}, 16'd0);
        reset = 1'b0;

        // 1: fade in. vol steps on every 2nd tick, so it is 63 at tick 127 and 64 at tick 128.
        run_ticks(126, 16'h4000);
        tick_once(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("fadein_vol63_d_l", r_dl, 16'hBF00);
        tick_once(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("fadein_vol64_d_l", r_dl, 16'hC000);
        tick_once(1'b1, 16'h2000, 16'h1000, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("latency_d_l_at_T4", r_dpre, 16'hC000);
        check_eq("latency_d_l_at_T5", r_dl, 16'hA000);
        check_eq("latency_d_r_at_T5", r_dr, 16'h9000);
        check_eq("run_a_ready", {15'd0, r_ra}, 16'd1);
        check_eq("run_b_ready_disabled", {15'd0, r_rb}, 16'd0);
        check_eq("run_no_underrun", {15'd0, r_und}, 16'd0);
        check_eq("a_ready_idle_clk", {15'd0, bus.a_ready}, 16'd0);

        // 2: saturating mix
        tick_once(1'b1, 16'h7000, 16'h7000, 1'b1, 1'b1, 16'h7000, 16'h7000);
        check_eq("sat_pos_d_l", r_dl, 16'hFFFF);
        check_eq("sat_pos_d_r", r_dr, 16'hFFFF);
        check_eq("sat_pos_clipped", {15'd0, r_clp}, 16'd1);
        check_eq("b_ready_enabled", {15'd0, r_rb}, 16'd1);
        tick_once(1'b1, 16'h9000, 16'h9000, 1'b1, 1'b1, 16'h9000, 16'h9000);
        check_eq("sat_neg_d_l", r_dl, 16'h0000);
        check_eq("sat_neg_clipped", {15'd0, r_clp}, 16'd1);
        tick_once(1'b1, 16'h1000, 16'hFF00, 1'b1, 1'b1, 16'h0234, 16'h0000);
        check_eq("mix_d_l", r_dl, 16'h9234);
        check_eq("mix_d_r", r_dr, 16'h7F00);
        check_eq("mix_no_clip", {15'd0, r_clp}, 16'd0);

        // 4: B disabled contributes 0; underruns repeat the held sample
        tick_once(1'b1, 16'h0555, 16'h0555, 1'b0, 1'b0, 16'h7777, 16'h7777);
        check_eq("b_disabled_d_l", r_dl, 16'h8555);
        tick_once(1'b0, 16'h7777, 16'h7777, 1'b0, 1'b0, 16'h7777, 16'h7777);
        check_eq("a_underrun_pulse", {15'd0, r_und}, 16'd1);
        check_eq("a_underrun_ready", {15'd0, r_ra}, 16'd1);
        check_eq("a_underrun_repeat", r_dl, 16'h8555);
        tick_once(1'b1, 16'h0100, 16'h0100, 1'b1, 1'b0, 16'h7777, 16'h7777);
        check_eq("b_underrun_pulse", {15'd0, r_und}, 16'd1);
        check_eq("b_underrun_held_cleared", r_dl, 16'h8100);

        // 3 + 5: fade out. vol is 32 after 64 ticks and 1 at tick 127, and TERM is entered on tick 128.
        pulse_shutdown();
        run_ticks(64, 16'h0000);
        tick_once(1'b1, 16'hFFFF, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("vol32_floor_d_l", r_dl, 16'h7FFF);
        check_eq("vol32_d_r", r_dr, 16'hA000);
        run_ticks(61, 16'h4000);
        tick_once(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("vol1_d_l", r_dl, 16'h8100);
        check_eq("pre_term_terminate", {15'd0, bus.terminate}, 16'd0);
        tick_once(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("term_terminate", {15'd0, bus.terminate}, 16'd1);
        check_eq("term_ack", {15'd0, bus.shutdown_ack}, 16'd1);
        check_eq("term_d_l", bus.d_l, 16'h8000);
        tick_once(1'b1, 16'h4000, 16'h4000, 1'b1, 1'b1, 16'h4000, 16'h4000);
        check_eq("term_a_ready", {15'd0, r_ra}, 16'd0);
        check_eq("term_b_ready", {15'd0, r_rb}, 16'd0);
        check_eq("term_d_l_hold", r_dl, 16'h8000);
        check_eq("term_no_underrun", {15'd0, r_und}, 16'd0);

        // Asynchronous reset out of TERM
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("areset_term_terminate", {15'd0, bus.terminate}, 16'd0);
        check_eq("areset_term_ack", {15'd0, bus.shutdown_ack}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        // 6: reset during FADE_OUT at vol 20
        run_ticks(128, 16'h4000);
        pulse_shutdown();
        run_ticks(88, 16'h4000);
        tick_once(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("fadeout_vol20_d_l", r_dl, 16'h9400);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("areset_fade_d_l", bus.d_l, 16'h8000);
        check_eq("areset_fade_d_r", bus.d_r, 16'h8000);
        check_eq("areset_fade_terminate", {15'd0, bus.terminate}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        tick_once(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("post_reset_vol0_d_l", r_dl, 16'h8000);
        tick_once(1'b1, 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("post_reset_vol1_d_l", r_dl, 16'h8100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
